// File: rtl/cordic_addsub_pipe.sv
// cordic_addsub_pipe: pipelined signed add/sub with saturate-or-wrap overflow and valid/ready stall
module cordic_addsub_pipe #(
  parameter int WORD_WIDTH = 16,
  parameter int STAGES = 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  input  logic                  sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf,
  output logic                  ovf_sticky,
  input  logic                  clr_ovf
);
  localparam int W = WORD_WIDTH;
  logic          en;
  logic [W:0]    a_x, b_x, r;
  logic          ov;
  logic [W-1:0]  res;
  logic [W-1:0]  data_q [STAGES];
  logic [STAGES-1:0] vld_q, ovf_q;
  logic          sticky_q, sticky_d;
  assign out_valid  = vld_q[STAGES-1];
  assign ovf        = ovf_q[STAGES-1];
  assign out        = data_q[STAGES-1];
  assign en         = ~out_valid | out_ready;
  assign in_ready   = en;
  assign ovf_sticky = sticky_q;
  // Stage-1 arithmetic on a one-bit-wider sign-extended word so the true result is never lost
  always_comb begin
    a_x = {A[W-1], A};
    b_x = {B[W-1], B};
    r   = sub ? a_x - b_x : a_x + b_x;
    ov  = r[W] ^ r[W-1];
    res = (SATURATE && ov) ? (r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : r[W-1:0];
  end
  // Whole pipeline advances together on en; ovf is only ever stored alongside a valid entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else if (en) begin
      vld_q[0]  <= in_valid;
      ovf_q[0]  <= in_valid & ov;
      data_q[0] <= res;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        ovf_q[i]  <= ovf_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  // Sticky flag: an overflowing output transfer beats a simultaneous clear
  always_comb sticky_d = (out_valid & out_ready & ovf) | (sticky_q & ~clr_ovf);
  // Sticky register
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
endmodule

// File: tb/tb_cordic_addsub_pipe.sv
// tb_cordic_addsub_pipe: randomized self-checking bench for both overflow modes against a queue model
module tb_cordic_addsub_pipe;
  localparam int W = 16;
  localparam int STG = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] a_r = '0, b_r = '0;
  logic sub_r = 1'b0, in_valid = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
  logic ir_s, ir_w, ov_s, ov_w, ovf_s, ovf_w, st_s, st_w;
  logic [W-1:0] o_s, o_w;
  always #5 clk = ~clk;

  cordic_addsub_pipe #(.WORD_WIDTH(W), .STAGES(STG), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .A(a_r), .B(b_r), .sub(sub_r), .in_valid(in_valid), .in_ready(ir_s),
    .out(o_s), .out_valid(ov_s), .out_ready(out_ready), .ovf(ovf_s), .ovf_sticky(st_s), .clr_ovf(clr_ovf));
  cordic_addsub_pipe #(.WORD_WIDTH(W), .STAGES(STG), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .A(a_r), .B(b_r), .sub(sub_r), .in_valid(in_valid), .in_ready(ir_w),
    .out(o_w), .out_valid(ov_w), .out_ready(out_ready), .ovf(ovf_w), .ovf_sticky(st_w), .clr_ovf(clr_ovf));

  typedef struct {logic [W-1:0] rs; logic [W-1:0] rw; logic ov; int age;} ent_t;
  ent_t q[$];
  logic sticky = 1'b0;
  int tests = 0, fails = 0;
  int dut_xfers = 0, exp_xfers = 0;

  function automatic logic [39:0] obs();
    return {ov_s, ov_w, ir_s, ir_w, ovf_s, ovf_w, st_s, st_w, ov_s ? o_s : 16'h0, ov_w ? o_w : 16'h0};
  endfunction

  function automatic logic [39:0] expv();
    logic v, r;
    v = q.size() > 0 && q[0].age == STG;
    r = !v || out_ready;
    return {v, v, r, r, v ? q[0].ov : 1'b0, v ? q[0].ov : 1'b0, sticky, sticky,
            v ? q[0].rs : 16'h0, v ? q[0].rw : 16'h0};
  endfunction

  function automatic int rnd_op();
    int k;
    k = int'($urandom_range(0, 7));
    return k == 0 ? 32767 : k == 1 ? -32768 : int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Drive one cycle; the model counts enabled edges since acceptance and exposes an entry at STG
  task automatic step(input logic v, input int a, input int b, input logic s, input logic ordy, input logic clr, output logic acc);
    logic head, en;
    int r;
    ent_t e;
    in_valid = v; a_r = 16'(a); b_r = 16'(b); sub_r = s; out_ready = ordy; clr_ovf = clr;
    if (ov_s && ordy) dut_xfers++;
    @(posedge clk);
    head = q.size() > 0 && q[0].age == STG;
    en = !head || ordy;
    if (head && ordy) exp_xfers++;
    if (head && ordy && q[0].ov) sticky = 1'b1;
    else if (clr) sticky = 1'b0;
    if (en) begin
      if (head) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (v) begin
        r = s ? a - b : a + b;
        e.ov = r > 32767 || r < -32768;
        e.rs = e.ov ? (r > 0 ? 16'h7fff : 16'h8000) : 16'(r);
        e.rw = 16'(r);
        e.age = 1;
        q.push_back(e);
      end
    end
    acc = en;
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if (obs() !== {8'b0011_0000, 32'h0}) begin
      fails++; $display("FAIL reset_flags got %h exp %h", obs(), {8'b0011_0000, 32'h0});
    end
    tests++;
    if ({o_s, o_w} !== 32'h0) begin
      fails++; $display("FAIL reset_out got %h exp 0", {o_s, o_w});
    end
  endtask

  task automatic test_add();
    logic acc;
    step(1, 156, 12, 0, 1, 0, acc);
    tests++;
    if (obs() !== expv() || ov_s !== 1'b0) begin fails++; $display("FAIL add_lat1 got %h exp %h", obs(), expv()); end
    step(1, 148, 45, 0, 1, 0, acc);
    tests++;
    if (obs() !== expv() || o_s !== 16'd168 || ov_s !== 1'b1 || ovf_s !== 1'b0) begin
      fails++; $display("FAIL add_first got %0d/%b exp 168/1", o_s, ov_s);
    end
    step(0, 0, 0, 0, 1, 0, acc);
    tests++;
    if (obs() !== expv() || o_s !== 16'd193 || ov_s !== 1'b1) begin
      fails++; $display("FAIL add_second got %0d/%b exp 193/1", o_s, ov_s);
    end
    step(0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_sub_neg();
    logic acc;
    step(1, -100, 250, 1, 1, 0, acc);
    step(0, 0, 0, 0, 1, 0, acc);
    tests++;
    if (o_s !== 16'hfea2 || o_w !== 16'hfea2 || ovf_s !== 1'b0 || ov_s !== 1'b1) begin
      fails++; $display("FAIL sub_neg got %h/%h ovf %b exp fea2 ovf 0", o_s, o_w, ovf_s);
    end
    step(0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int seen = 0;
    for (int i = 0; i < 8 + STG + 1; i++) begin
      if (i < 8) step(1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1, 0, acc);
      else step(0, 0, 0, 0, 1, 0, acc);
      if (ov_s) seen++;
      tests++;
      if (obs() !== expv()) begin fails++; $display("FAIL stream_cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    tests++;
    if (seen !== 8) begin fails++; $display("FAIL stream_count got %0d exp 8", seen); end
  endtask

  task automatic test_overflow();
    logic acc;
    step(1, 32767, 1, 0, 1, 0, acc);
    step(1, -32768, 1, 1, 1, 0, acc);
    tests++;
    if (o_s !== 16'h7fff || o_w !== 16'h8000 || ovf_s !== 1'b1 || ovf_w !== 1'b1) begin
      fails++; $display("FAIL ovf_pos got %h/%h ovf %b exp 7fff/8000 ovf 1", o_s, o_w, ovf_s);
    end
    step(1, 0, -32768, 1, 1, 0, acc);
    tests++;
    if (o_s !== 16'h8000 || o_w !== 16'h7fff || ovf_s !== 1'b1 || st_s !== 1'b1 || obs() !== expv()) begin
      fails++; $display("FAIL ovf_neg got %h/%h sticky %b exp 8000/7fff sticky 1", o_s, o_w, st_s);
    end
    step(0, 0, 0, 0, 1, 0, acc);
    tests++;
    if (o_s !== 16'h7fff || o_w !== 16'h8000 || ovf_w !== 1'b1) begin
      fails++; $display("FAIL ovf_minb got %h/%h exp 7fff/8000", o_s, o_w);
    end
    step(0, 0, 0, 0, 1, 1, acc);
    tests++;
    if (st_s !== 1'b1 || st_w !== 1'b1 || obs() !== expv()) begin
      fails++; $display("FAIL sticky_set_wins got %b exp 1", st_s);
    end
    step(0, 0, 0, 0, 1, 1, acc);
    tests++;
    if (st_s !== 1'b0 || st_w !== 1'b0 || obs() !== expv()) begin
      fails++; $display("FAIL sticky_clear got %b exp 0", st_s);
    end
    step(0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [W-1:0] held;
    int a, b;
    for (int i = 0; i < 3; i++) step(1, rnd_op(), rnd_op(), 0, 1, 0, acc);
    held = o_s;
    a = rnd_op(); b = rnd_op();
    for (int i = 0; i < 3; i++) begin
      step(1, a, b, 1, 0, 0, acc);
      tests++;
      if (ir_s !== 1'b0 || ir_w !== 1'b0 || o_s !== held || ov_s !== 1'b1 || obs() !== expv()) begin
        fails++; $display("FAIL stall_cyc%0d got ready %b out %h exp ready 0 out %h", i, ir_s, o_s, held);
      end
    end
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      step(1, a, b, 1, 1, 0, acc);
      tests++;
      if (obs() !== expv()) begin fails++; $display("FAIL resume_cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    for (int i = 0; i < STG + 1; i++) begin
      step(0, 0, 0, 0, 1, 0, acc);
      tests++;
      if (obs() !== expv()) begin fails++; $display("FAIL drain_cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    tests++;
    if (dut_xfers !== exp_xfers || ov_s !== 1'b0) begin
      fails++; $display("FAIL bp_count got %0d exp %0d", dut_xfers, exp_xfers);
    end
  endtask

  task automatic test_random();
    logic acc = 1'b1;
    logic v = 1'b0, s = 1'b0;
    int a = 0, b = 0;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (acc || !v) begin
        v = 1'($urandom_range(0, 3) != 0); a = rnd_op(); b = rnd_op(); s = 1'($urandom_range(0, 1));
      end
      step(v, a, b, s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), acc);
      tests++;
      if (obs() !== expv()) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL random_cyc%0d got %h exp %h", i, obs(), expv());
      end
    end
    for (int i = 0; i < STG + 1; i++) step(0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_async_reset();
    logic acc;
    step(1, 32767, 1, 0, 1, 0, acc);
    step(1, 1, 2, 0, 1, 0, acc);
    step(1, 3, 4, 0, 1, 0, acc);
    tests++;
    if (st_s !== 1'b1 || ov_s !== 1'b1) begin fails++; $display("FAIL pre_reset got sticky %b valid %b exp 1 1", st_s, ov_s); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({ov_s, ov_w, st_s, st_w, ovf_s, ovf_w} !== 6'b0) begin
      fails++; $display("FAIL async_reset got %b exp 000000", {ov_s, ov_w, st_s, st_w, ovf_s, ovf_w});
    end
    q.delete(); sticky = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, acc);
      tests++;
      if (obs() !== expv() || ov_s !== 1'b0) begin fails++; $display("FAIL stale_cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    step(1, 5, 6, 0, 1, 0, acc);
    step(0, 0, 0, 0, 1, 0, acc);
    tests++;
    if (o_s !== 16'd11 || ov_s !== 1'b1) begin fails++; $display("FAIL post_reset got %0d/%b exp 11/1", o_s, ov_s); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub_neg();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cordic_addsub_pipe.md
Name: cordic_addsub_pipe

Overview:
Parametrised, pipelined signed adder/subtractor that replaces the combinational Adder in the CORDIC vectoring datapath. It adds or subtracts per transaction, as required by the rotate-direction decision of each CORDIC micro-rotation. Overflow handling is selectable (saturate or wrap), with a sticky overflow flag. It uses a valid/ready handshake so that the iteration controller can stall it.

Parameters:
WORD_WIDTH, 16, operand and result width in bits (signed two's complement, >=4)
STAGES, 2, pipeline depth in register stages (1..4); equals input-to-output latency in cycles
SATURATE, 1, 1 = clamp on overflow to max/min; 0 = wrap modulo 2^WORD_WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
A  input  WORD_WIDTH  signed operand A
B  input  WORD_WIDTH  signed operand B
sub  input  1  0: out = A + B; 1: out = A - B
in_valid  input  1  A/B/sub valid this cycle
in_ready  output  1  unit can accept a transaction this cycle
out  output  WORD_WIDTH  signed result
out_valid  output  1  out/ovf hold a valid result
out_ready  input  1  downstream accepts result this cycle
ovf  output  1  result of current out overflowed (qualified by out_valid)
ovf_sticky  output  1  set by any accepted-result overflow, held until clr_ovf
clr_ovf  input  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; out = 0, out_valid = 0, ovf = 0, ovf_sticky = 0; in_ready = 1 one delta after reset release (combinational).
- Global enable: en = !out_valid | out_ready. in_ready = en (combinational; no in_valid->in_ready path).
- When en=1, every stage shifts one position; stage 1 captures (in_valid, result). When en=0, all stages hold (no bubble collapse).
- Transfer at input: in_valid & in_ready. Transfer at output: out_valid & out_ready.
- Latency: exactly STAGES enabled cycles from input transfer to out_valid=1. With en held high, throughput is 1 per cycle.
- Arithmetic in stage 1: sign-extend A and B to WORD_WIDTH+1; compute A + B or A + (~B + 1); full result R.
- Overflow: R[WORD_WIDTH] != R[WORD_WIDTH-1]. This includes A - (-2^(W-1)) cases.
- SATURATE=1: on overflow, out = 2^(W-1)-1 if R is positive (R[W]=0), else -2^(W-1). SATURATE=0: out = R[W-1:0].
- ovf travels with its data through the stages. Stages 2..STAGES are pure delay registers for data, ovf and valid.
- ovf_sticky: set in the cycle of an output transfer with ovf=1. clr_ovf clears it. If clr_ovf and a setting event occur in the same cycle, set wins.
- Invalid stage contents: out holds the last value (not required to zero). ovf must be 0 whenever out_valid=0.
- Reset mid-operation flushes all in-flight transactions; no result is emitted for them.
- in_valid with in_ready=0: the transaction is not taken; the source holds it (standard valid/ready).

Test Plan:
- STAGES=2, SATURATE=1, out_ready=1: A=156,B=12,sub=0 then A=148,B=45,sub=0 on consecutive cycles -> out=168 then 193, two cycles after each input transfer, ovf=0.
- Subtract with negative: A=-100,B=250,sub=1 -> out=-350, ovf=0. Streaming 8 back-to-back ops -> 8 results, in order, one per cycle.
- Overflow SATURATE=1: A=32767,B=1,sub=0 -> out=32767, ovf=1, ovf_sticky=1. Next, A=-32768,B=1,sub=1 -> out=-32768, ovf=1. Then clr_ovf pulse -> ovf_sticky=0.
- Overflow SATURATE=0: A=32767,B=1,sub=0 -> out=-32768, ovf=1. A=0,B=-32768,sub=1 -> out=-32768, ovf=1.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, out stable, no transaction lost or duplicated after out_ready returns to 1.
- Async reset asserted between clock edges with 2 transactions in flight -> out_valid=0, ovf_sticky=0 immediately; no stale result after release.
